// File: rtl/up_pwm_multi.sv
// up_pwm_multi: register-programmable multi-channel PWM generator.
//
// A single free-running counter (cnt) shared by all channels sweeps
// 0..PERIOD. Each channel compares its phase-shifted position against its
// own duty value. PERIOD/DUTY/PHASE are written into shadow registers and
// copied to the active set atomically, either at a period end (running) or
// on the cycle after the load request (stopped), so outputs never glitch.
//
// Register map (word offsets from ADDR_BASE, 64-word window):
//   0x00 VERSION (RO)   0x01 CONTROL {load, enable}   0x02 PERIOD
//   0x10+n DUTY[n]      0x20+n PHASE[n]
//
// Ports:
//   up_clk, up_rstn           clock, asynchronous active-low reset
//   up_wreq/up_waddr/up_wdata write request, up_wack one cycle later
//   up_rreq/up_raddr          read request, up_rack/up_rdata one cycle later
//   pwm_out[CHANNELS-1:0]     registered PWM outputs
module up_pwm_multi #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DATA_WIDTH = 12,
  parameter logic [13:0] ADDR_BASE  = 14'h0000
) (
  input  logic                up_clk,
  input  logic                up_rstn,
  input  logic                up_wreq,
  input  logic [13:0]         up_waddr,
  input  logic [31:0]         up_wdata,
  output logic                up_wack,
  input  logic                up_rreq,
  input  logic [13:0]         up_raddr,
  output logic [31:0]         up_rdata,
  output logic                up_rack,
  output logic [CHANNELS-1:0] pwm_out
);

  localparam logic [31:0]         VERSION = 32'h0001_0000;
  localparam logic [DATA_WIDTH:0] ONE     = 1;

  logic [13:0] woff;
  logic [13:0] roff;
  logic        w_in;
  logic        r_in;

  assign woff = up_waddr - ADDR_BASE;
  assign roff = up_raddr - ADDR_BASE;
  assign w_in = (woff[13:6] == 8'd0);
  assign r_in = (roff[13:6] == 8'd0);

  logic                  enable;
  logic                  load_pend;
  logic [DATA_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] period_sh;
  logic [DATA_WIDTH-1:0] period_act;
  logic [DATA_WIDTH-1:0] duty_sh   [CHANNELS];
  logic [DATA_WIDTH-1:0] duty_act  [CHANNELS];
  logic [DATA_WIDTH-1:0] phase_sh  [CHANNELS];
  logic [DATA_WIDTH-1:0] phase_act [CHANNELS];

  // Write decode
  logic                wr_ctrl;
  logic                wr_period;
  logic [CHANNELS-1:0] wr_duty;
  logic [CHANNELS-1:0] wr_phase;
  logic                load_wr;
  logic                period_end;
  logic                load_now;

  always_comb begin
    wr_ctrl   = up_wreq && w_in && (woff[5:0] == 6'h01);
    wr_period = up_wreq && w_in && (woff[5:0] == 6'h02);
    wr_duty   = '0;
    wr_phase  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_duty[i]  = up_wreq && w_in && (woff[5:0] == (6'h10 + 6'(i)));
      wr_phase[i] = up_wreq && w_in && (woff[5:0] == (6'h20 + 6'(i)));
    end
  end

  // A load request arriving exactly at a period end is honoured at that
  // same edge instead of waiting a full extra period.
  assign load_wr    = wr_ctrl && up_wdata[1];
  assign period_end = enable && (cnt == period_act);
  assign load_now   = (period_end && (load_pend || load_wr)) || (!enable && load_pend);

  // Read mux
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (roff[5:0])
      6'h00: rd_mux = VERSION;
      6'h01: rd_mux = {30'd0, load_pend, enable};
      6'h02: rd_mux = 32'(period_sh);
      default: begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (roff[5:0] == (6'h10 + 6'(i))) rd_mux = 32'(duty_sh[i]);
          if (roff[5:0] == (6'h20 + 6'(i))) rd_mux = 32'(phase_sh[i]);
        end
      end
    endcase
  end

  // Per-channel position within the period, shifted by phase. One extra
  // bit keeps the wrapped branch free of overflow. Phase beyond the
  // period has no position in the sweep, so that channel stays low.
  logic [DATA_WIDTH:0] pos [CHANNELS];
  logic [CHANNELS-1:0] pwm_next;

  always_comb begin
    pwm_next = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pos[i] = '0;
      if (cnt >= phase_act[i])
        pos[i] = {1'b0, cnt} - {1'b0, phase_act[i]};
      else
        pos[i] = {1'b0, cnt} + {1'b0, period_act} + ONE - {1'b0, phase_act[i]};
      pwm_next[i] = enable && (phase_act[i] <= period_act) &&
                    (pos[i] < {1'b0, duty_act[i]});
    end
  end

  // Bus acknowledge and read data
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      up_wack  <= 1'b0;
      up_rack  <= 1'b0;
      up_rdata <= '0;
    end else begin
      up_wack  <= up_wreq && w_in;
      up_rack  <= up_rreq && r_in;
      up_rdata <= (up_rreq && r_in) ? rd_mux : '0;
    end
  end

  // Control, counter and output
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      enable    <= 1'b0;
      load_pend <= 1'b0;
      cnt       <= '0;
      pwm_out   <= '0;
    end else begin
      if (wr_ctrl) enable <= up_wdata[0];

      if (load_now)     load_pend <= 1'b0;
      else if (load_wr) load_pend <= 1'b1;

      if (!enable || period_end) cnt <= '0;
      else                       cnt <= cnt + 1'b1;

      pwm_out <= pwm_next;
    end
  end

  // Shadow and active register sets
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      period_sh  <= '0;
      period_act <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        duty_sh[i]   <= '0;
        duty_act[i]  <= '0;
        phase_sh[i]  <= '0;
        phase_act[i] <= '0;
      end
    end else begin
      if (load_now) begin
        period_act <= period_sh;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          duty_act[i]  <= duty_sh[i];
          phase_act[i] <= phase_sh[i];
        end
      end
      if (wr_period) period_sh <= up_wdata[DATA_WIDTH-1:0];
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (wr_duty[i])  duty_sh[i]  <= up_wdata[DATA_WIDTH-1:0];
        if (wr_phase[i]) phase_sh[i] <= up_wdata[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: doc/up_pwm_multi.md
UP_PWM_MULTI -- requirements
Module: up_pwm_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of PWM outputs, legal range 1..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 12, width of the period, duty and phase fields, legal range 4..31.
REQ-003 SHALL have parameter ADDR_BASE, default 14'h0000, word address of register 0.
REQ-004 SHALL have up_clk, input, 1 bit, the single clock for all logic.
REQ-005 SHALL have up_rstn, input, 1 bit, reset: asynchronous, active-low.
REQ-006 SHALL have up_wreq, up_waddr, up_wdata, inputs of 1, 14 and 32 bits, the register write request.
REQ-007 SHALL have up_wack, output, 1 bit, the write acknowledge.
REQ-008 SHALL have up_rreq and up_raddr, inputs of 1 and 14 bits, the register read request.
REQ-009 SHALL have up_rdata and up_rack, outputs of 32 and 1 bits, the read data and read acknowledge.
REQ-010 SHALL have pwm_out, output, CHANNELS bits, the registered PWM outputs.

Function
REQ-011 SHALL decode word offsets from ADDR_BASE as follows:
  0x00 VERSION: read-only, 32'h0001_0000.
  0x01 CONTROL: bit0 enable; bit1 load, write 1 to set, self-clearing.
  0x02 PERIOD.
  0x10+n DUTY[n].
  0x20+n PHASE[n].
  n ranges 0..CHANNELS-1.
REQ-012 SHALL assert up_wack and up_rack exactly one cycle after the matching request, only for addresses inside the 64-word window at ADDR_BASE.
REQ-013 SHALL drive up_rdata to 0 whenever up_rack is low.
REQ-014 SHALL return 0 with rack for unmapped in-window reads, and SHALL ignore unmapped in-window writes while still acking them.
REQ-015 SHALL hold PERIOD, DUTY and PHASE writes in shadow registers (low DATA_WIDTH bits of wdata) and SHALL return the shadow values on readback.
REQ-016 SHALL read CONTROL bit1 as 1 while a load is pending.
REQ-017 SHALL keep a free-running counter cnt: cnt=PERIOD_act gives cnt=0 next cycle, otherwise cnt+1, while enable=1.
REQ-018 SHALL hold cnt at 0 while enable=0.
REQ-019 SHALL copy all shadows to the active registers in one cycle when a load is pending, under either condition below:
  (a) enable=1 and cnt=PERIOD_act, with the next period using the new values;
  (b) enable=0, on the cycle after the load write.
  The load bit SHALL then clear.
REQ-020 SHALL, when a load write and a period-end coincide, apply the load at that period-end.
REQ-021 SHALL, when shadows are rewritten while a load is pending, latch the latest values at load time.
REQ-022 SHALL compute, per channel, pos = cnt-PHASE_act if cnt>=PHASE_act, else cnt+PERIOD_act+1-PHASE_act, using DATA_WIDTH+1-bit arithmetic with no overflow.
REQ-023 SHALL set pwm_out[n] to the registered value of (enable && pos<DUTY_act[n]), one cycle after the corresponding cnt.
REQ-024 SHALL make pwm_out[n] constant high when DUTY_act[n]>PERIOD_act, and constant low when DUTY_act[n]=0.
REQ-025 SHALL make pwm_out[n] constant low when PHASE_act[n]>PERIOD_act.
REQ-026 SHALL, with PERIOD_act=0, hold cnt at 0 and give each output as (DUTY_act[n]!=0).
REQ-027 SHALL, when enable is cleared mid-period, set cnt to 0 on the next cycle and all pwm_out low one cycle later.
REQ-028 SHALL, when enable is set, start counting from cnt=0.

Reset
REQ-029 SHALL, on up_rstn low, asynchronously clear: cnt, enable, load pending, all shadow and active registers, pwm_out, up_wack, up_rack and up_rdata.
REQ-030 SHALL, on reset asserted mid-period or with a load pending, discard all state, leaving no pending load after release.
REQ-031 SHALL NOT acknowledge requests during reset, and SHALL acknowledge normally starting with the first request after release.

Verification
REQ-032 Basic PWM: CHANNELS=4, DATA_WIDTH=12; PERIOD=9, DUTY0=3, PHASE0=0, load with enable=0, then enable -> pwm_out[0] high 3 / low 7 cycles, period 10 cycles; VERSION reads 32'h0001_0000.
REQ-033 Phase offset: PERIOD=9, DUTY1=4, PHASE1=8 -> pwm_out[1] high for cnt in {8,9,0,1}, one cycle after those cnt values.
REQ-034 Glitch-free update: running with DUTY0=3, write DUTY0=7 and load at cnt=4 -> current period keeps 3 high cycles, the next has 7; CONTROL bit1 reads 1 until the wrap, then 0.
REQ-035 Extremes: DUTY2=0 -> constant low; DUTY3=12 with PERIOD=9 -> constant high; PHASE0=15 with PERIOD=9 -> channel 0 constant low; PERIOD=0, DUTY0=1 -> constant high.
REQ-036 Bus: read of unmapped offset 0x3F -> rack 1 cycle later with data 0; address outside the window -> no ack; write then read of DUTY0=12'hFFF -> 32'h0000_0FFF.
REQ-037 Reset mid-operation: assert up_rstn low with a load pending at cnt=5 -> pwm_out=0 and all registers read 0 after release; enable=1 is then required before any output toggles.
